branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised bimodal branch predictor with a tagged branch target buffer (BTB) for the RV32 pipeline. The core currently resolves every branch in EX/MEM and flushes on each taken one; this block lets the fetch stage redirect early.
- Lookup side: indexed by the fetch PC; returns a registered taken/target prediction one cycle later.
- Update side: driven by the resolving stage with the actual outcome.
- Also counts mispredictions for performance monitoring.

## Interface
- ENTRIES, 64: table depth; power of two, ≥ 2; IDX_W = log2(ENTRIES).
- TAG_BITS, 8: tag width; tag = pc[IDX_W+TAG_BITS:IDX_W+1].
- CTR_BITS, 2: saturating counter width, ≥ 1.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- lookup_valid_i  in  1  fetch presents lookup_pc_i this cycle.
- lookup_pc_i  in  [31:1]  fetch PC; index = pc[IDX_W:1].
- stall_i  in  1  holds prediction outputs.
- flush_i  in  1  kills pending prediction.
- clear_i  in  1  invalidates every entry.
- pred_valid_o  out  1  prediction outputs are meaningful.
- pred_taken_o  out  1  predicted taken.
- pred_target_o  out  [31:1]  predicted target; 0 when not hit.
- upd_valid_i  in  1  resolved instruction presented.
- upd_pc_i  in  [31:1]  PC of resolved instruction.
- upd_is_branch_i  in  1  conditional branch.
- upd_is_jump_i  in  1  JAL/JALR.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  [31:1]  actual target.
- upd_mispredict_i  in  1  pipeline flushed for this instruction.
- mispredict_cnt_o  out  32  misprediction counter.

## Operation
- Entry fields: valid, tag, target[31:1], ctr[CTR_BITS-1:0], is_jump.
- Hit: entry valid and tag equal.
- Prediction: taken = hit & (is_jump | ctr[MSB]); target = entry.target on hit, else 0.
- Update (upd_valid_i, branch or jump):
  - Hit: ctr saturating +1 if taken, −1 if not; target overwritten when taken; is_jump rewritten.
  - Miss and taken: allocate (overwrite), ctr = 2^(CTR_BITS-1) (weakly taken).
  - Miss and not taken: no change.
- upd_valid_i with neither branch nor jump, on hit: entry invalidated (stale alias).
- upd_is_branch_i and upd_is_jump_i both high: treated as jump.
- mispredict_cnt_o: +1 on upd_valid_i & upd_mispredict_i; wraps at 2^32.
- clear_i: all valid bits cleared next edge; targets, counters and mispredict_cnt_o untouched.
  - clear_i overrides a same-cycle update.

## Timing
- Reset (async): all valid = 0, ctr = 0, pred_valid_o = 0, pred_taken_o = 0, pred_target_o = 0, mispredict_cnt_o = 0.
- Lookup latency: 1 cycle.
  - Edge after lookup_valid_i & !stall_i: pred_* registers load the prediction for lookup_pc_i.
  - pred_valid_o = 1 only if lookup_valid_i was high; otherwise pred_valid_o and pred_taken_o go 0.
- stall_i high: pred_* hold value.
- flush_i: next edge pred_valid_o = 0, pred_taken_o = 0; flush beats stall.
- Table write at the clock edge. A lookup in the same cycle as an update to the same index sees pre-update contents; the new contents are visible from the next lookup.
- Update is single-cycle; no backpressure; an update is accepted every cycle.
- Reset mid-operation: immediate return to reset values; no partial writes survive.

## Test plan
- Reset, then lookup pc 0x100 (lookup_pc_i = 0x80) -> next cycle pred_valid_o = 1, pred_taken_o = 0, pred_target_o = 0; mispredict_cnt_o = 0.
- Update 0x100 branch, taken, target 0x200 -> lookup 0x100 next cycle gives taken, target 0x200 (half-word 0x100). Same-cycle lookup still gives not-taken.
- Training with CTR_BITS = 2 after allocation (ctr = 2):
  - Two not-taken updates -> ctr 0, predicts not taken.
  - One taken update -> ctr 1, still not taken.
  - Second taken update -> ctr 2, taken.
  - Five taken updates saturate at 3.
- Aliasing with ENTRIES = 64: allocate 0x100, then lookup 0x180 (same index 0, different tag) -> miss, pred_taken_o = 0.
  - Allocating 0x180 evicts 0x100.
  - A non-branch update at 0x180 invalidates it.
- Jump at 0x40 allocated taken -> predicts taken regardless of ctr.
  - clear_i with a same-cycle update to 0x40 -> all lookups miss afterwards.
- Stall, flush and counter:
  - Stall across two cycles holds the prediction.
  - flush_i with stall_i forces pred_valid_o = 0.
  - Preloading mispredict_cnt_o to 0xFFFF_FFFF via 2^32 − 1 events (or a forced counter) then one more mispredict wraps it to 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a tagged BTB: registered lookup one cycle after fetch,
// single-cycle update from the resolving stage, and a free-running misprediction counter.
`timescale 1ns/1ps
module branch_predictor #(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lookup_valid_i,
  input  logic [31:1] lookup_pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        clear_i,
  output logic        pred_valid_o,
  output logic        pred_taken_o,
  output logic [31:1] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:1] upd_pc_i,
  input  logic        upd_is_branch_i,
  input  logic        upd_is_jump_i,
  input  logic        upd_taken_i,
  input  logic [31:1] upd_target_i,
  input  logic        upd_mispredict_i,
  output logic [31:0] mispredict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TOP   = IDX_W + TAG_BITS + 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_ONE << (CTR_BITS - 1);

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:1]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic                jmp_q    [ENTRIES];

  logic                pred_valid_q, pred_valid_d;
  logic                pred_taken_q, pred_taken_d;
  logic [31:1]         pred_target_q, pred_target_d;
  logic [31:0]         cnt_q, mispredict_cnt_q;

  logic [IDX_W-1:0]    l_idx, u_idx;
  logic [TAG_BITS-1:0] l_tag, u_tag;
  logic                l_hit, l_taken, u_hit;
  logic [31:1]         l_target;
  logic                wr_en, inv_en;
  logic [CTR_BITS-1:0] ctr_d;
  logic [31:1]         tgt_d;
  logic                jmp_d;

  // PC bits above the tag never participate in indexing or matching.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[31:TOP], upd_pc_i[31:TOP], cnt_q};

  // Lookup reads the pre-edge table, so a same-cycle update is not yet visible.
  always_comb begin
    l_idx    = lookup_pc_i[IDX_W:1];
    l_tag    = lookup_pc_i[IDX_W+TAG_BITS:IDX_W+1];
    l_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    l_taken  = l_hit && (jmp_q[l_idx] || ctr_q[l_idx][CTR_BITS-1]);
    l_target = l_hit ? target_q[l_idx] : '0;

    pred_valid_d  = pred_valid_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (flush_i) begin
      pred_valid_d  = 1'b0;
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
    end else if (!stall_i) begin
      pred_valid_d  = lookup_valid_i;
      pred_taken_d  = lookup_valid_i && l_taken;
      pred_target_d = lookup_valid_i ? l_target : '0;
    end
  end

  always_comb begin
    u_idx  = upd_pc_i[IDX_W:1];
    u_tag  = upd_pc_i[IDX_W+TAG_BITS:IDX_W+1];
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    wr_en  = 1'b0;
    inv_en = 1'b0;
    ctr_d  = ctr_q[u_idx];
    tgt_d  = target_q[u_idx];
    jmp_d  = jmp_q[u_idx];
    if (upd_valid_i && !clear_i) begin
      if (upd_is_branch_i || upd_is_jump_i) begin
        if (u_hit) begin
          wr_en = 1'b1;
          if (upd_taken_i) begin
            ctr_d = (ctr_q[u_idx] == CTR_MAX) ? ctr_q[u_idx] : ctr_q[u_idx] + CTR_ONE;
            tgt_d = upd_target_i;
          end else begin
            ctr_d = (ctr_q[u_idx] == '0) ? ctr_q[u_idx] : ctr_q[u_idx] - CTR_ONE;
          end
          jmp_d = upd_is_jump_i;
        end else if (upd_taken_i) begin
          wr_en = 1'b1;
          ctr_d = CTR_WEAK;
          tgt_d = upd_target_i;
          jmp_d = upd_is_jump_i;
        end
      end else if (u_hit) begin
        inv_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
        jmp_q[i]    <= 1'b0;
      end
    end else if (clear_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= tgt_d;
      ctr_q[u_idx]    <= ctr_d;
      jmp_q[u_idx]    <= jmp_d;
    end else if (inv_en) begin
      valid_q[u_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_target_q    <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      if (upd_valid_i && upd_mispredict_i) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign cnt_q            = mispredict_cnt_q;
  assign pred_valid_o     = pred_valid_q;
  assign pred_taken_o     = pred_taken_q;
  assign pred_target_o    = pred_target_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor: each vector drives one cycle and queues the
// outputs expected after the following edge; hand sequences cover reset and counter wrap.
`timescale 1ns/1ps
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid, stall, flush, clear;
  logic [31:1] lookup_pc;
  logic        pred_valid, pred_taken;
  logic [31:1] pred_target;
  logic        upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_mispredict;
  logic [31:1] upd_pc, upd_target;
  logic [31:0] mispredict_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .TAG_BITS(8), .CTR_BITS(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .lookup_valid_i(lookup_valid), .lookup_pc_i(lookup_pc),
    .stall_i(stall), .flush_i(flush), .clear_i(clear),
    .pred_valid_o(pred_valid), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
    .upd_is_branch_i(upd_is_branch), .upd_is_jump_i(upd_is_jump),
    .upd_taken_i(upd_taken), .upd_target_i(upd_target),
    .upd_mispredict_i(upd_mispredict), .mispredict_cnt_o(mispredict_cnt)
  );

  // Addresses in the table are byte addresses; the ports carry bits [31:1].
  typedef struct {
    string       name;
    bit [2:0]    ctl;    // {stall, flush, clear}
    bit          lv;
    logic [31:0] lpc;
    bit [3:0]    u;      // {valid, branch, jump, taken}
    logic [31:0] upc;
    logic [31:0] utgt;
    bit          um;
    bit          ev;
    bit          et;
    logic [31:0] etgt;
    logic [31:0] ecnt;
  } vec_t;

  typedef struct {
    string       name;
    bit          ev;
    bit          et;
    logic [31:0] etgt;
    logic [31:0] ecnt;
  } exp_t;

  localparam bit [3:0] NO = 4'b0000, BT = 4'b1101, BN = 4'b1100, JT = 4'b1011,
                       BJN = 4'b1110, NB = 4'b1000;
  localparam bit [2:0] C0 = 3'b000, ST = 3'b100, SF = 3'b110, CL = 3'b001;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[$];

  function automatic vec_t mk(string n, bit [2:0] ctl, bit lv, logic [31:0] lpc, bit [3:0] u,
                              logic [31:0] upc, logic [31:0] utgt, bit um, bit ev, bit et,
                              logic [31:0] etgt, logic [31:0] ecnt);
    vec_t v;
    v.name = n; v.ctl = ctl; v.lv = lv; v.lpc = lpc; v.u = u; v.upc = upc; v.utgt = utgt;
    v.um = um; v.ev = ev; v.et = et; v.etgt = etgt; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".valid"}, 32'(pred_valid), 32'(e.ev));
      chk({e.name, ".taken"}, 32'(pred_taken), 32'(e.et));
      if (e.ev) chk({e.name, ".target"}, {pred_target, 1'b0}, e.etgt);
      chk({e.name, ".cnt"}, mispredict_cnt, e.ecnt);
    end
  endtask

  task automatic drive_idle();
    {stall, flush, clear} = 3'b000;
    lookup_valid = 1'b0; lookup_pc = '0;
    {upd_valid, upd_is_branch, upd_is_jump, upd_taken} = 4'b0000;
    upd_pc = '0; upd_target = '0; upd_mispredict = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    {stall, flush, clear} = v.ctl;
    lookup_valid = v.lv; lookup_pc = v.lpc[31:1];
    {upd_valid, upd_is_branch, upd_is_jump, upd_taken} = v.u;
    upd_pc = v.upc[31:1]; upd_target = v.utgt[31:1]; upd_mispredict = v.um;
    e.name = v.name; e.ev = v.ev; e.et = v.et; e.etgt = v.etgt; e.ecnt = v.ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e0;
    e0.name = "reset"; e0.ev = 0; e0.et = 0; e0.etgt = '0; e0.ecnt = '0;

    //          name          ctl lv lpc     upd  upc     utgt    um ev et etgt    cnt
    vecs.push_back(mk("cold",       C0, 1, 32'h100, NO, 32'h0,   32'h0,   0, 1, 0, 32'h0,   0));
    vecs.push_back(mk("alloc_same", C0, 1, 32'h100, BT, 32'h100, 32'h200, 1, 1, 0, 32'h0,   1));
    vecs.push_back(mk("hit_taken",  C0, 1, 32'h100, NO, 32'h0,   32'h0,   0, 1, 1, 32'h200, 1));
    vecs.push_back(mk("nt_a",       C0, 0, 32'h0,   BN, 32'h100, 32'h0,   1, 0, 0, 32'h0,   2));
    vecs.push_back(mk("nt_b",       C0, 1, 32'h100, BN, 32'h100, 32'h0,   0, 1, 0, 32'h200, 2));
    vecs.push_back(mk("nt_sat0",    C0, 1, 32'h100, BN, 32'h100, 32'h0,   1, 1, 0, 32'h200, 3));
    vecs.push_back(mk("tk_from0",   C0, 1, 32'h100, BT, 32'h100, 32'h200, 0, 1, 0, 32'h200, 3));
    vecs.push_back(mk("tk_from1",   C0, 1, 32'h100, BT, 32'h100, 32'h200, 0, 1, 0, 32'h200, 3));
    vecs.push_back(mk("ctr2_taken", C0, 1, 32'h100, NO, 32'h0,   32'h0,   0, 1, 1, 32'h200, 3));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("tk_sat",   C0, 0, 32'h0,   BT, 32'h100, 32'h200, 0, 0, 0, 32'h0,   3));
    vecs.push_back(mk("tk_sat_tgt", C0, 0, 32'h0,   BT, 32'h100, 32'h240, 1, 0, 0, 32'h0,   4));
    vecs.push_back(mk("sat3",       C0, 1, 32'h100, BN, 32'h100, 32'h0,   0, 1, 1, 32'h240, 4));
    vecs.push_back(mk("ctr2",       C0, 1, 32'h100, BN, 32'h100, 32'h0,   0, 1, 1, 32'h240, 4));
    vecs.push_back(mk("ctr1",       C0, 1, 32'h100, NO, 32'h0,   32'h0,   0, 1, 0, 32'h240, 4));
    vecs.push_back(mk("alias_miss", C0, 1, 32'h180, NO, 32'h0,   32'h0,   0, 1, 0, 32'h0,   4));
    vecs.push_back(mk("evict_same", C0, 1, 32'h100, BT, 32'h180, 32'h300, 1, 1, 0, 32'h240, 5));
    vecs.push_back(mk("evicted",    C0, 1, 32'h100, NO, 32'h0,   32'h0,   0, 1, 0, 32'h0,   5));
    vecs.push_back(mk("alias_hit",  C0, 1, 32'h180, NO, 32'h0,   32'h0,   0, 1, 1, 32'h300, 5));
    vecs.push_back(mk("nonbr_same", C0, 1, 32'h180, NB, 32'h180, 32'h0,   0, 1, 1, 32'h300, 5));
    vecs.push_back(mk("nonbr_inv",  C0, 1, 32'h180, NO, 32'h0,   32'h0,   0, 1, 0, 32'h0,   5));
    vecs.push_back(mk("jmp_alloc",  C0, 0, 32'h0,   JT, 32'h40,  32'h80,  0, 0, 0, 32'h0,   5));
    vecs.push_back(mk("jmp_bj_nt",  C0, 1, 32'h40,  BJN, 32'h40, 32'h0,   0, 1, 1, 32'h80,  5));
    vecs.push_back(mk("jmp_bj_nt2", C0, 0, 32'h0,   BJN, 32'h40, 32'h0,   1, 0, 0, 32'h0,   6));
    vecs.push_back(mk("jmp_ctr0",   C0, 1, 32'h40,  NO, 32'h0,   32'h0,   0, 1, 1, 32'h80,  6));
    vecs.push_back(mk("realloc",    C0, 0, 32'h0,   BT, 32'h100, 32'h200, 0, 0, 0, 32'h0,   6));
    vecs.push_back(mk("pre_clear",  C0, 1, 32'h100, NO, 32'h0,   32'h0,   0, 1, 1, 32'h200, 6));
    vecs.push_back(mk("clear_upd",  CL, 1, 32'h40,  JT, 32'h40,  32'hC0,  0, 1, 1, 32'h80,  6));
    vecs.push_back(mk("clr_miss40", C0, 1, 32'h40,  NO, 32'h0,   32'h0,   0, 1, 0, 32'h0,   6));
    vecs.push_back(mk("clr_miss100",C0, 1, 32'h100, NO, 32'h0,   32'h0,   0, 1, 0, 32'h0,   6));
    vecs.push_back(mk("realloc2",   C0, 0, 32'h0,   BT, 32'h100, 32'h200, 0, 0, 0, 32'h0,   6));
    vecs.push_back(mk("pre_stall",  C0, 1, 32'h100, NO, 32'h0,   32'h0,   0, 1, 1, 32'h200, 6));
    vecs.push_back(mk("stall1",     ST, 1, 32'h40,  NO, 32'h0,   32'h0,   0, 1, 1, 32'h200, 6));
    vecs.push_back(mk("stall2",     ST, 0, 32'h0,   NO, 32'h0,   32'h0,   0, 1, 1, 32'h200, 6));
    vecs.push_back(mk("flush_stall",SF, 1, 32'h100, NO, 32'h0,   32'h0,   0, 0, 0, 32'h0,   6));
    vecs.push_back(mk("post_flush", C0, 1, 32'h100, NO, 32'h0,   32'h0,   0, 1, 1, 32'h200, 6));
    vecs.push_back(mk("no_lookup",  C0, 0, 32'h0,   NO, 32'h0,   32'h0,   0, 0, 0, 32'h0,   6));

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(e0);
    check_out();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Asynchronous reset mid-cycle: outputs clear before any edge, table empties.
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = 31'h80;
    #2 rst = 1'b1;
    #1;
    e0.name = "async_reset";
    sb.push_back(e0);
    check_out();
    @(negedge clk);
    rst = 1'b0;
    apply(mk("post_reset", C0, 1, 32'h100, NO, 32'h0, 32'h0, 0, 1, 0, 32'h0, 0));

    // Counter wrap from all-ones.
    @(negedge clk);
    drive_idle();
    force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.mispredict_cnt_q;
    #1 chk("cnt_preload", mispredict_cnt, 32'hFFFF_FFFF);
    apply(mk("cnt_wrap", C0, 0, 32'h0, NB, 32'h400, 32'h0, 1, 0, 0, 32'h0, 0));
    apply(mk("cnt_hold", C0, 0, 32'h0, NO, 32'h0,   32'h0, 0, 0, 0, 32'h0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
